// File: rtl/freq_sys_pkg.sv
// Shared types and constants for the frequency measurement and configuration system.
package freq_sys_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS,
        DONE
    } state_e;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_OUT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // All-ones value of a counter of the given width: the timeout limit and the saturation ceiling.
    function automatic int unsigned cnt_limit(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous level input.
// Also produces a one-cycle strobe on the synchronised rising edge.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_adjust_ctrl.sv
// Measures 2^n periods of infreq in clk cycles on an adj request.
// Loads the truncated average period, clipped to OUT_W bits, into period_out.
module freq_adjust_ctrl
    import freq_sys_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adj,
    input  logic             infreq,
    input  logic [2:0]       n,
    output logic [OUT_W-1:0] period_out,
    output logic             load,
    output logic             busy,
    output logic             timeout,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(cnt_limit(CNT_W));
    localparam logic [CNT_W:0]   OUT_MAX   = (CNT_W + 1)'(cnt_limit(OUT_W));

    logic adj_rise;
    logic infreq_rise;

    sync_edge #(.STAGES(SYNC_STAGES)) u_adj_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (adj),
        .rise  (adj_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_infreq_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (infreq),
        .rise  (infreq_rise)
    );

    state_e           state_q,   state_d;
    logic [2:0]       n_q,       n_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [7:0]       per_cnt_q, per_cnt_d;
    logic [CNT_W:0]   total_q,   total_d;
    logic [OUT_W-1:0] period_q,  period_d;
    logic             load_q,    load_d;
    logic             busy_q,    busy_d;
    logic             timeout_q, timeout_d;
    logic             sat_q,     sat_d;

    logic [8:0]       per_next;
    logic [8:0]       per_target;
    logic             terminal_edge;
    logic             cnt_at_limit;
    logic [CNT_W:0]   result;

    assign per_next      = {1'b0, per_cnt_q} + 9'd1;
    assign per_target    = 9'd1 << n_q;
    assign terminal_edge = infreq_rise && (per_next == per_target);
    assign cnt_at_limit  = (cnt_q == CNT_LIMIT);
    assign result        = total_q >> n_q;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        per_cnt_d = per_cnt_q;
        total_d   = total_q;
        period_d  = period_q;
        load_d    = 1'b0;
        timeout_d = timeout_q;
        sat_d     = sat_q;

        unique case (state_q)
            IDLE: begin
                if (adj_rise) begin
                    n_d       = n;
                    timeout_d = 1'b0;
                    sat_d     = 1'b0;
                    cnt_d     = '0;
                    per_cnt_d = '0;
                    state_d   = ARM;
                end
            end

            ARM: begin
                if (infreq_rise) begin
                    cnt_d     = '0;
                    per_cnt_d = '0;
                    state_d   = MEAS;
                end else if (cnt_at_limit) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // A terminal edge on the limit cycle still completes: the total is exact.
            MEAS: begin
                if (terminal_edge) begin
                    total_d = {1'b0, cnt_q} + 1'b1;
                    state_d = DONE;
                end else if (cnt_at_limit) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (infreq_rise) begin
                        per_cnt_d = per_next[7:0];
                    end
                end
            end

            DONE: begin
                if (result > OUT_MAX) begin
                    period_d = OUT_MAX[OUT_W-1:0];
                    sat_d    = 1'b1;
                end else begin
                    period_d = result[OUT_W-1:0];
                end
                load_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            cnt_q     <= '0;
            per_cnt_q <= '0;
            total_q   <= '0;
            period_q  <= '0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            per_cnt_q <= per_cnt_d;
            total_q   <= total_d;
            period_q  <= period_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            sat_q     <= sat_d;
        end
    end

    assign period_out = period_q;
    assign load       = load_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_freq_adjust_ctrl.sv
// Directed bench for freq_adjust_ctrl: a table of measurement vectors,
// followed by hand-written retrigger, timeout and mid-run reset sequences.
`timescale 1ns/1ps
module tb_freq_adjust_ctrl;

    logic       clk;
    logic       rst;
    logic       adj;
    logic       infreq;
    logic [2:0] n;
    logic [7:0] period_out;
    logic       load;
    logic       busy;
    logic       timeout;
    logic       sat;

    int checks   = 0;
    int failures = 0;
    int load_cnt = 0;

    int infreq_per = 200;
    bit infreq_en  = 1'b0;

    typedef struct {
        int n;
        int per_ns;
        int lo;
        int hi;
        int sat;
    } vec_t;

    vec_t vecs[8];

    freq_adjust_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .adj        (adj),
        .infreq     (infreq),
        .n          (n),
        .period_out (period_out),
        .load       (load),
        .busy       (busy),
        .timeout    (timeout),
        .sat        (sat)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // infreq edges start on negedges of clk so that exact-multiple periods sample identically
    initial begin
        infreq = 1'b0;
        forever begin
            if (infreq_en) begin
                infreq = 1'b1;
                #(infreq_per / 2);
                infreq = 1'b0;
                #(infreq_per - infreq_per / 2);
            end else begin
                @(negedge clk);
            end
        end
    end

    always @(negedge clk) begin
        if (load === 1'b1) load_cnt++;
    end

    task automatic check_output(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Pulses adj for four cycles and checks busy rises exactly three negedges after adj goes high.
    task automatic apply_stimulus(input int nv, input int per_ns, input string tag);
        n          = 3'(nv);
        infreq_per = per_ns;
        infreq_en  = 1'b1;
        repeat (2) @(negedge clk);
        load_cnt = 0;
        adj = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output({tag, "_busy_pre"}, int'(busy), 0, 0);
        @(negedge clk);
        check_output({tag, "_busy_rise"}, int'(busy), 1, 1);
        @(negedge clk);
        adj = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int max_cycles, output int cycles);
        cycles = 0;
        while (busy !== lvl && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
        end
        if (busy !== lvl) cycles = -1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        apply_stimulus(v.n, v.per_ns, tag);
        wait_busy(1'b0, 20000, cyc);
        check_output({tag, "_finished"}, (cyc >= 0) ? 1 : 0, 1, 1);
        repeat (3) @(negedge clk);
        check_output({tag, "_loads"}, load_cnt, 1, 1);
        check_output({tag, "_period"}, int'(period_out), v.lo, v.hi);
        check_output({tag, "_sat"}, int'(sat), v.sat, v.sat);
        check_output({tag, "_timeout"}, int'(timeout), 0, 0);
    endtask

    initial begin
        int cyc;
        vec_t post;

        vecs[0] = '{n: 2, per_ns: 200,  lo: 10,  hi: 10,  sat: 0};
        vecs[1] = '{n: 3, per_ns: 198,  lo: 9,   hi: 10,  sat: 0};
        vecs[2] = '{n: 0, per_ns: 198,  lo: 9,   hi: 10,  sat: 0};
        vecs[3] = '{n: 1, per_ns: 6000, lo: 255, hi: 255, sat: 1};
        vecs[4] = '{n: 2, per_ns: 200,  lo: 10,  hi: 10,  sat: 0};
        vecs[5] = '{n: 7, per_ns: 200,  lo: 10,  hi: 10,  sat: 0};
        vecs[6] = '{n: 5, per_ns: 140,  lo: 7,   hi: 7,   sat: 0};
        vecs[7] = '{n: 4, per_ns: 400,  lo: 20,  hi: 20,  sat: 0};

        rst = 1'b0;
        adj = 1'b0;
        n   = 3'd0;
        #100;
        rst = 1'b1;

        @(negedge clk);
        check_output("rst_period", int'(period_out), 0, 0);
        check_output("rst_load", int'(load), 0, 0);
        check_output("rst_busy", int'(busy), 0, 0);
        check_output("rst_timeout", int'(timeout), 0, 0);
        check_output("rst_sat", int'(sat), 0, 0);
        load_cnt = 0;
        repeat (50) @(negedge clk);
        check_output("idle_busy", int'(busy), 0, 0);
        check_output("idle_loads", load_cnt, 0, 0);
        check_output("idle_period", int'(period_out), 0, 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Retrigger and n change during MEAS: the original n=2 must end the run after 4 periods
        apply_stimulus(2, 200, "retrig");
        repeat (16) @(negedge clk);
        check_output("retrig_in_meas", int'(busy), 1, 1);
        adj = 1'b1;
        n   = 3'd5;
        repeat (3) @(negedge clk);
        adj = 1'b0;
        wait_busy(1'b0, 2000, cyc);
        check_output("retrig_duration", (cyc < 0) ? 99999 : cyc + 23, 45, 90);
        repeat (20) @(negedge clk);
        check_output("retrig_loads", load_cnt, 1, 1);
        check_output("retrig_period", int'(period_out), 10, 10);
        check_output("retrig_no_restart", int'(busy), 0, 0);

        // Timeout with infreq parked low: busy must drop exactly 65539 negedges after adj goes high
        infreq_en = 1'b0;
        repeat (40) @(negedge clk);
        check_output("to_infreq_low", int'(infreq), 0, 0);
        apply_stimulus(0, 200, "to");
        infreq_en = 1'b0;
        wait_busy(1'b0, 70000, cyc);
        check_output("to_cycles", (cyc < 0) ? -1 : cyc + 4, 65539, 65539);
        repeat (3) @(negedge clk);
        check_output("to_flag", int'(timeout), 1, 1);
        check_output("to_busy", int'(busy), 0, 0);
        check_output("to_loads", load_cnt, 0, 0);
        check_output("to_period_kept", int'(period_out), 10, 10);

        post = '{n: 1, per_ns: 200, lo: 10, hi: 10, sat: 0};
        run_vec(post, "post_to");

        // Reset asserted mid-measurement clears everything at once and issues no load
        apply_stimulus(7, 200, "mrst");
        repeat (100) @(negedge clk);
        check_output("mrst_in_meas", int'(busy), 1, 1);
        #5;
        rst = 1'b0;
        #1;
        check_output("mrst_period", int'(period_out), 0, 0);
        check_output("mrst_busy", int'(busy), 0, 0);
        check_output("mrst_load", int'(load), 0, 0);
        check_output("mrst_timeout", int'(timeout), 0, 0);
        check_output("mrst_sat", int'(sat), 0, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check_output("mrst_loads", load_cnt, 0, 0);
        check_output("mrst_idle", int'(busy), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
